// File: rtl/tick_meter_pkg.sv
// ============================================================================
//  Module  : tick_meter_pkg
//  Brief   : State type and encoding shared by the tick interval meter.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package tick_meter_pkg;

   localparam int c_STATE_W = 2;

   localparam logic [c_STATE_W-1:0] c_ST_IDLE       = 2'd0;
   localparam logic [c_STATE_W-1:0] c_ST_WAIT_FIRST = 2'd1;
   localparam logic [c_STATE_W-1:0] c_ST_MEASURE    = 2'd2;

   typedef enum logic [c_STATE_W-1:0] {
      IDLE       = c_ST_IDLE,
      WAIT_FIRST = c_ST_WAIT_FIRST,
      MEASURE    = c_ST_MEASURE
   } tick_meter_state_t;

   function automatic logic st_busy(input tick_meter_state_t s);
      return (s != IDLE);
   endfunction

endpackage

`default_nettype wire

// File: rtl/tick_meter_outreg.sv
// ============================================================================
//  Module  : tick_meter_outreg
//  Brief   : Single-entry valid/ready result register. With
//            TICK_METER_OVERRUN_EN a result arriving on a held entry is
//            dropped and flagged; otherwise it overwrites the held entry.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_meter_outreg #(
   parameter int W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         ready,
   output logic [W-1:0] data,
   output logic         valid
`ifdef TICK_METER_OVERRUN_EN
   ,
   output logic         overrun
`endif
);

   logic [W-1:0] r_data;
   logic         r_valid;
   logic         w_held;

   // An entry is "held" when it is valid and not being consumed on this edge.
   assign w_held = r_valid && !ready;

`ifdef TICK_METER_OVERRUN_EN
   logic r_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_overrun <= 1'b0;
      end else if (load && w_held) begin
         r_overrun <= 1'b1;
      end
   end

   assign overrun = r_overrun;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (load) begin
         if (w_held) begin
`ifndef TICK_METER_OVERRUN_EN
            r_data <= load_data;
`endif
         end else begin
            r_data  <= load_data;
            r_valid <= 1'b1;
         end
      end else if (r_valid && ready) begin
         r_valid <= 1'b0;
      end
   end

   assign data  = r_data;
   assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/tick_interval_meter.sv
// ============================================================================
//  Module  : tick_interval_meter
//  Brief   : Counts clk cycles between tick strobes, reports each interval
//            through a valid/ready register and pulses timeout after
//            MAX_COUNT idle cycles. Optional: TICK_METER_OVERRUN_EN.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_interval_meter
   import tick_meter_pkg::*;
#(
   parameter  int MAX_COUNT = 1023,
   localparam int W         = $clog2(MAX_COUNT + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         enable,
   input  logic         tick,
   output logic [W-1:0] period,
   output logic         period_valid,
   input  logic         period_ready,
   output logic         timeout,
   output logic         busy
`ifdef TICK_METER_OVERRUN_EN
   ,
   output logic         overrun
`endif
);

   localparam logic [W-1:0] c_MAX = W'(MAX_COUNT);
   localparam logic [W-1:0] c_ONE = W'(1);

   tick_meter_state_t r_state;
   tick_meter_state_t w_state_nxt;
   logic [W-1:0]      r_count;
   logic [W-1:0]      w_count_nxt;
   logic              w_load;
   logic              w_timeout_nxt;
   logic              r_timeout;
   logic              r_busy;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_timeout <= 1'b0;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_count   <= w_count_nxt;
         r_timeout <= w_timeout_nxt;
         r_busy    <= st_busy(w_state_nxt);
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_count_nxt   = r_count;
      w_load        = 1'b0;
      w_timeout_nxt = 1'b0;

      if (!enable) begin
         w_state_nxt = IDLE;
         w_count_nxt = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = WAIT_FIRST;
               w_count_nxt = '0;
            end
            WAIT_FIRST: begin
               if (tick) begin
                  w_state_nxt = MEASURE;
                  w_count_nxt = c_ONE;
               end
            end
            MEASURE: begin
               // A tick landing on count == MAX_COUNT still wins over timeout.
               if (tick) begin
                  w_load      = 1'b1;
                  w_count_nxt = c_ONE;
               end else if (r_count == c_MAX) begin
                  w_timeout_nxt = 1'b1;
                  w_count_nxt   = '0;
                  w_state_nxt   = WAIT_FIRST;
               end else begin
                  w_count_nxt = r_count + c_ONE;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_count_nxt = '0;
            end
         endcase
      end
   end

   tick_meter_outreg #(
      .W (W)
   ) u_outreg (
      .clk       (clk),
      .reset     (reset),
      .load      (w_load),
      .load_data (r_count),
      .ready     (period_ready),
      .data      (period),
      .valid     (period_valid)
`ifdef TICK_METER_OVERRUN_EN
      ,
      .overrun   (overrun)
`endif
   );

   assign timeout = r_timeout;
   assign busy    = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_tick_interval_meter.sv
// ============================================================================
//  Module  : tb_tick_interval_meter
//  Brief   : Self-checking bench for tick_interval_meter (MAX_COUNT = 1023),
//            covers both TICK_METER_OVERRUN_EN builds.
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_interval_meter;

   localparam int MAX = 1023;
   localparam int W   = 10;

   logic         clk = 1'b0;
   logic         reset;
   logic         enable;
   logic         tick;
   logic         period_ready;
   logic [W-1:0] period;
   logic         period_valid;
   logic         timeout;
   logic         busy;
`ifdef TICK_METER_OVERRUN_EN
   logic         overrun;
`endif

   tick_interval_meter #(
      .MAX_COUNT (MAX)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .tick         (tick),
      .period       (period),
      .period_valid (period_valid),
      .period_ready (period_ready),
      .timeout      (timeout),
      .busy         (busy)
`ifdef TICK_METER_OVERRUN_EN
      ,
      .overrun      (overrun)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: timestamps of ticks rather than a cycle counter.
   int cyc     = 0;
   bit m_idle  = 1'b1;
   bit m_armed = 1'b0;
   int m_last  = 0;
   int m_per   = 0;
   bit m_v     = 1'b0;
   bit m_to    = 1'b0;
   bit m_ovr   = 1'b0;

   typedef struct {
      bit r, e, t, y;
      int per;
      bit v, to, bsy;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input bit r, input bit e, input bit t, input bit y);
      bit newres;
      int nv;
      newres = 1'b0;
      nv     = 0;
      cyc++;
      m_to = 1'b0;
      if (r) begin
         m_idle = 1'b1; m_armed = 1'b0; m_per = 0; m_v = 1'b0; m_ovr = 1'b0;
         return;
      end
      if (!e) begin
         m_idle = 1'b1; m_armed = 1'b0;
      end else if (m_idle) begin
         m_idle = 1'b0;
      end else if (!m_armed) begin
         if (t) begin m_armed = 1'b1; m_last = cyc; end
      end else if (t) begin
         newres = 1'b1; nv = cyc - m_last; m_last = cyc;
      end else if (cyc - m_last == MAX) begin
         m_to = 1'b1; m_armed = 1'b0;
      end
      if (newres) begin
         if (m_v && !y) begin
`ifdef TICK_METER_OVERRUN_EN
            m_ovr = 1'b1;
`else
            m_per = nv;
`endif
         end else begin
            m_per = nv; m_v = 1'b1;
         end
      end else if (m_v && y) begin
         m_v = 1'b0;
      end
   endtask

   task automatic step(input bit r, input bit e, input bit t, input bit y);
      reset = r; enable = e; tick = t; period_ready = y;
      @(posedge clk);
      model_edge(r, e, t, y);
      #1;
      chk("period", 32'(period), 32'(m_per));
      chk("period_valid", 32'(period_valid), 32'(m_v));
      chk("timeout", 32'(timeout), 32'(m_to));
      chk("busy", 32'(busy), 32'(!m_idle));
`ifdef TICK_METER_OVERRUN_EN
      chk("overrun", 32'(overrun), 32'(m_ovr));
`endif
   endtask

   task automatic idle_steps(input int n, input bit y);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, y);
   endtask

   // Reset, enable, then a first tick: leaves the meter in MEASURE, count 1.
   task automatic restart(input bit y);
      step(1'b1, 1'b0, 1'b0, y);
      step(1'b0, 1'b1, 1'b0, y);
      step(1'b0, 1'b1, 1'b1, y);
   endtask

   vec_t vt[11];

   initial begin
      int nres;
      bit to_seen;
      int den;
      bit ry;

      reset = 1'b1; enable = 1'b0; tick = 1'b0; period_ready = 1'b0;

      //         r  e  t  y   per v  to bsy
      vt[0]  = '{1, 0, 1, 0,  0,  0, 0, 0};
      vt[1]  = '{1, 1, 0, 0,  0,  0, 0, 0};
      vt[2]  = '{1, 1, 1, 0,  0,  0, 0, 0};
      vt[3]  = '{0, 1, 1, 0,  0,  0, 0, 1};  // tick ignored in IDLE
      vt[4]  = '{0, 1, 1, 0,  0,  0, 0, 1};  // first tick starts measurement
      vt[5]  = '{0, 1, 1, 0,  1,  1, 0, 1};  // back-to-back -> 1
      vt[6]  = '{0, 1, 0, 0,  1,  1, 0, 1};
      vt[7]  = '{0, 1, 0, 1,  1,  0, 0, 1};  // consumed
      vt[8]  = '{0, 1, 1, 0,  3,  1, 0, 1};
      vt[9]  = '{0, 0, 0, 0,  3,  1, 0, 0};  // disable keeps pending result
      vt[10] = '{0, 0, 0, 1,  3,  0, 0, 0};

      for (int i = 0; i < 11; i++) begin
         step(vt[i].r, vt[i].e, vt[i].t, vt[i].y);
         chk("vec_period", 32'(period), 32'(vt[i].per));
         chk("vec_valid", 32'(period_valid), 32'(vt[i].v));
         chk("vec_timeout", 32'(timeout), 32'(vt[i].to));
         chk("vec_busy", 32'(busy), 32'(vt[i].bsy));
      end

      // Periodic ticks every 256 cycles
      step(1'b1, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      nres = 0;
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1);
         if (i > 0) begin
            chk("periodic_period", 32'(period), 32'd256);
            if (period_valid === 1'b1) nres++;
         end
         idle_steps(255, 1'b1);
      end
      chk("periodic_results", 32'(nres), 32'd9);

      // Back-to-back ticks
      step(1'b0, 1'b1, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, 1'b1, 1'b1);
         chk("b2b_period", 32'(period), 32'd1);
         chk("b2b_valid", 32'(period_valid), 32'd1);
      end

      // Gap of exactly MAX: valid result, no timeout
      to_seen = 1'b0;
      for (int i = 0; i < MAX - 1; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b1);
         if (timeout !== 1'b0) to_seen = 1'b1;
      end
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("gapmax_period", 32'(period), 32'd1023);
      chk("gapmax_valid", 32'(period_valid), 32'd1);
      chk("gapmax_no_timeout", 32'(to_seen | timeout), 32'd0);

      // Gap of MAX+1: timeout, no result, next tick restarts
      idle_steps(MAX - 1, 1'b1);
      chk("gap_pre_timeout", 32'(timeout), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("gap_timeout", 32'(timeout), 32'd1);
      chk("gap_no_result", 32'(period_valid), 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("gap_timeout_once", 32'(timeout), 32'd0);
      chk("gap_restart_noresult", 32'(period_valid), 32'd0);
      idle_steps(9, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("gap_restart_period", 32'(period), 32'd10);

      // Simultaneous consume and load
      restart(1'b0);
      idle_steps(19, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("sim_first", 32'(period), 32'd20);
      idle_steps(4, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("sim_period", 32'(period), 32'd5);
      chk("sim_valid", 32'(period_valid), 32'd1);
`ifdef TICK_METER_OVERRUN_EN
      chk("sim_no_overrun", 32'(overrun), 32'd0);
`endif

      // Backpressure: 100 then 50 apart with ready low
      restart(1'b0);
      idle_steps(99, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("bp_first", 32'(period), 32'd100);
      idle_steps(49, 1'b0);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("bp_valid", 32'(period_valid), 32'd1);
`ifdef TICK_METER_OVERRUN_EN
      chk("bp_period_held", 32'(period), 32'd100);
      chk("bp_overrun", 32'(overrun), 32'd1);
`else
      chk("bp_period_over", 32'(period), 32'd50);
`endif

      // Mid-operation abort
      restart(1'b1);
      idle_steps(39, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_valid", 32'(period_valid), 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("abort_no_result", 32'(period_valid), 32'd0);
      idle_steps(29, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      chk("abort_period", 32'(period), 32'd30);

      // Randomized segments of varying tick density and backpressure
      for (int s = 0; s < 60; s++) begin
         case ($urandom_range(0, 3))
            0:       den = 2;
            1:       den = 20;
            2:       den = 300;
            default: den = 2000;
         endcase
         ry = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 999) == 0),
                 ($urandom_range(0, 199) != 0),
                 ($urandom_range(0, den - 1) == 0),
                 ry ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
